fib_bcd_display: RTL
====================

# fib_bcd_display

Downstream display stage for the 16-bit Fibonacci test top. It consumes the `out0` result word through a valid/ready handshake and converts it to five BCD digits with a sequential double-dabble engine. It drives a 4-digit, active-low, multiplexed 7-segment display, and flags results of 10000 or more on the decimal points. It replaces the raw binary LED output with a readable decimal value on the board.

## Interface

**Parameters**

- `REFRESH_BITS`, default 17: width of the free-running scan counter; the top 2 bits select the active digit.
- `BLANK_LEADING`, default 1: when 1, leading zero digits are blanked; digit 0 is never blanked.

**Ports**

- `clk`  in  1: sole clock; everything is rising-edge.
- `nrst`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: `in0` holds a new value.
- `in_ready`  out  1: block is idle and can accept a value.
- `in0`  in  16: unsigned binary value.
- `bcd`  out  20: latched result, digits {d4,d3,d2,d1,d0}, with d0 at [3:0].
- `bcd_valid`  out  1: one-cycle pulse when `bcd` updates.
- `seg`  out  7: segment drive, active-low; bit0=a … bit6=g.
- `an`  out  4: digit enable, active-low; `an[0]` is the ones digit.
- `dp`  out  1: decimal point, active-low.

## Operation

**FSM**

- States: IDLE, SHIFT, DONE.
- `in_ready` = (state == IDLE). It is a combinational decode of the state register.
- IDLE: when `in_valid & in_ready` at an edge:
  - load `in0` into a 16-bit shift register;
  - clear the 20-bit scratch register;
  - clear the 5-bit step counter;
  - go to SHIFT.
- SHIFT: each edge performs one double-dabble step.
  - Every scratch nibble ≥ 5 gets +3, computed in 4 bits with no carry into the next nibble.
  - Then {scratch, shift} shifts left by 1.
  - The step counter increments.
  - After the 16th step, go to DONE.
- DONE: at the next edge:
  - `bcd` ← scratch;
  - `bcd_valid` ← 1 for exactly one cycle;
  - go to IDLE.
- `in_valid` outside IDLE is ignored. No value is captured or queued, and the upstream block must hold its data until `in_ready`.

**Arithmetic**

- The input range 0…65535 fits five digits.
- d4 is 0–6 and never exceeds 6.
- No overflow path exists.

**Display**

- The scan counter is free-running, `REFRESH_BITS` wide, and wraps to 0.
- sel = counter[top:top-1]. `an` = ~(1 << sel), so exactly one digit is active.
- `seg` decodes `bcd` digit[sel], active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blanking: digit k (k=1..3) shows `seg`=1111111 if `BLANK_LEADING`=1 and d4…dk are all zero.
- Overflow: when d4 ≠ 0 (value ≥ 10000), `dp`=0 on every digit; otherwise `dp`=1.
- The display always shows the last latched `bcd`. A conversion in progress does not disturb it.

**Reset**

- Applied at any time, including mid-conversion, reset forces the following at the next edge:
  - state IDLE;
  - `bcd` = 0;
  - `bcd_valid` = 0;
  - scan counter = 0;
  - step counter and scratch = 0.
- Any partial conversion is discarded.

## Timing

**Reset values of outputs**

- `in_ready`=1, `bcd`=0, `bcd_valid`=0.
- `an`=1110, `seg`=1000000 ('0'), `dp`=1.

**Handshake and latency**

- Acceptance happens at edge E, where `in_valid & in_ready` are sampled high.
- `in_ready` goes low after E.
- Shift steps occur at E+1…E+16.
- At E+17, `bcd` and `bcd_valid` update and `in_ready` returns high.
- The earliest next acceptance is edge E+18. Sustained throughput is one value per 18 cycles.
- `seg`/`an`/`dp` are combinational from `bcd` and the scan counter, so a new value appears on the display in the cycle after E+17.

**Scan rate**

- Digit switch every 2^(`REFRESH_BITS`-2) cycles.
- Full scan every 2^`REFRESH_BITS` cycles.

## Test plan

Use `REFRESH_BITS`=4 in the bench.

1. Reset held 3 cycles, then released → `in_ready`=1, `bcd`=0x00000, `an`=1110, `seg`=1000000, `dp`=1. The scan sequence is `an` 1110,1101,1011,0111 with 4 cycles per digit.
2. `in0`=46368 (fib 24) for one accept → `bcd`=0x46368 with a 1-cycle `bcd_valid` exactly 17 edges after acceptance. The display shows 6,3,6,8 with `dp`=0 on all digits.
3. `in0`=9999, then 65535 → `bcd`=0x09999 with `dp`=1, then 0x65535 with `dp`=0.
4. `in0`=7 with `BLANK_LEADING`=1 → `an[0]` shows 1111000 and digits 1–3 show 1111111. With `BLANK_LEADING`=0, digits 1–3 show 1000000.
5. `in_valid` held high continuously with the value changing every cycle → accepted values are spaced exactly 18 edges apart. Each `bcd` matches the value present at its acceptance edge, and values offered while busy are ignored.
6. `nrst` pulsed at edge E+8 of a conversion of 1234, with prior `bcd`=0x00055 → `bcd`=0, no `bcd_valid` pulse, and `in_ready`=1 the next cycle. A fresh accept of 1234 then yields 0x01234.

Source files
------------

// File: rtl/fib_bcd_display.sv
// ============================================================================
// Module   : fib_bcd_display
// Brief    : Handshaked 16-bit binary to 5-digit BCD converter (double dabble)
//            driving a 4-digit active-low multiplexed 7-segment display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fib_bcd_display #(
    parameter int REFRESH_BITS  = 17,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in0_i,
    output logic [19:0] bcd_o,
    output logic        bcd_valid_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        dp_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [4:0] c_LAST_STEP = 5'd15;

    logic [1:0]              state_q, state_d;
    logic [15:0]             shift_q, shift_d;
    logic [19:0]             scratch_q, scratch_d;
    logic [19:0]             scratch_adj;
    logic [4:0]              step_q, step_d;
    logic [19:0]             bcd_q, bcd_d;
    logic                    bcd_valid_q, bcd_valid_d;
    logic [REFRESH_BITS-1:0] scan_q;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!nrst_i) state_q <= c_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (in_valid_i) state_d = c_SHIFT;
            c_SHIFT: if (step_q == c_LAST_STEP) state_d = c_DONE;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_o = (state_q == c_IDLE);
    end

    // Per-nibble +3 correction stays inside each nibble; no carry propagates.
    always_comb begin
        scratch_adj = scratch_q;
        for (int k = 0; k < 5; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5)
                scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        step_d      = step_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (in_valid_i) begin
                    shift_d   = in0_i;
                    scratch_d = 20'd0;
                    step_d    = 5'd0;
                end
            end
            c_SHIFT: begin
                scratch_d = {scratch_adj[18:0], shift_q[15]};
                shift_d   = {shift_q[14:0], 1'b0};
                step_d    = step_q + 5'd1;
            end
            c_DONE: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            shift_q     <= 16'd0;
            scratch_q   <= 20'd0;
            step_q      <= 5'd0;
            bcd_q       <= 20'd0;
            bcd_valid_q <= 1'b0;
            scan_q      <= '0;
        end else begin
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            step_q      <= step_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            scan_q      <= scan_q + REFRESH_BITS'(1);
        end
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = bcd_valid_q;
    assign sel         = scan_q[REFRESH_BITS-1 -: 2];

    // Digit k is blanked when it and every more significant digit are zero.
    always_comb begin
        digit = bcd_q[{sel, 2'b00} +: 4];
        blank = 1'b0;
        if (BLANK_LEADING != 0) begin
            case (sel)
                2'd1:    blank = (bcd_q[19:4]  == 16'd0);
                2'd2:    blank = (bcd_q[19:8]  == 12'd0);
                2'd3:    blank = (bcd_q[19:12] == 8'd0);
                default: blank = 1'b0;
            endcase
        end
        seg_o = blank ? 7'b1111111 : seg_decode(digit);
        an_o  = ~(4'b0001 << sel);
        dp_o  = (bcd_q[19:16] == 4'd0);
    end

endmodule

`default_nettype wire
